uart_command_rx: RTL and testbench

Serial front end of the input path: oversampled 8N1 UART receiver plus packet assembler that turns a framed byte stream from the host into one render-command write (12-bit shape address, register address and data) with a single-cycle program strobe. Sits directly upstream of the input manager and drives its program/shape_addr/reg_addr/data inputs.

---
 rtl/uart_command_rx.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_command_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_command_rx.sv
// Oversampled 8N1 UART receiver plus packet assembler producing one render-command write per framed packet.
// Optional feature: define UART_RX_CHECKSUM_EN to require a sixth XOR checksum byte per packet.
module uart_command_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_input,
    output logic        program_out,
    output logic [11:0] shape_addr,
    output logic [11:0] reg_addr,
    output logic [11:0] data,
    output logic        frame_err
);

    localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
    localparam int          TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int          TO_W     = $clog2(TO_LIMIT + 1);
`ifdef UART_RX_CHECKSUM_EN
    localparam int          PW       = 40;
    localparam logic [2:0]  LAST_IDX = 3'd5;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`else
    localparam int          PW       = 32;
    localparam logic [2:0]  LAST_IDX = 3'd4;
`endif

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [0:0] {P_HUNT, P_PAYLOAD} pkt_state_t;

    logic              sync1_q, sync2_q, rx_s;
    bit_state_t        bit_state_q, bit_state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              start_det_s, stop_ok_s, stop_err_s;
    logic              byte_valid_q, stop_err_q;

    pkt_state_t        pkt_state_q, pkt_state_d;
    logic [2:0]        count_q, count_d;
    logic [PW-1:0]     payload_q, payload_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timeout_s;
    logic              program_q, program_d;
    logic [11:0]       shape_q, shape_d, reg_q, reg_d, data_q, data_d;
    logic              frame_err_q, frame_err_d;
`ifdef UART_RX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              csum_err_s;
`endif

    assign rx_s = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_input;
            sync2_q <= sync1_q;
        end
    end

    // Bit-level receiver: half-bit start qualification, then mid-bit sampling.
    always_comb begin
        bit_state_d = bit_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        start_det_s = 1'b0;
        stop_ok_s   = 1'b0;
        stop_err_s  = 1'b0;
        case (bit_state_q)
            B_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    bit_state_d = B_START;
                    start_det_s = 1'b1;
                end else begin
                    bit_state_d = B_IDLE;
                end
            end
            B_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d       = 16'd0;
                    bit_idx_d   = 3'd0;
                    bit_state_d = rx_s ? B_IDLE : B_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            B_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = B_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            B_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d       = 16'd0;
                    bit_state_d = B_IDLE;
                    stop_ok_s   = rx_s;
                    stop_err_s  = !rx_s;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                bit_state_d = B_IDLE;
                cnt_d       = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_state_q  <= B_IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            bit_state_q  <= bit_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= stop_ok_s;
            stop_err_q   <= stop_err_s;
        end
    end

    // Idle-gap timer only runs while a packet is open and the line is between frames.
    always_comb begin
        timeout_s = 1'b0;
        if (pkt_state_q == P_PAYLOAD && bit_state_q == B_IDLE && !start_det_s) begin
            to_cnt_d  = to_cnt_q + TO_W'(1);
            timeout_s = (to_cnt_q == TO_W'(TO_LIMIT - 1));
        end else begin
            to_cnt_d = '0;
        end
    end

    always_comb begin
        pkt_state_d = pkt_state_q;
        count_d     = count_q;
        payload_d   = payload_q;
        shape_d     = shape_q;
        reg_d       = reg_q;
        data_d      = data_q;
        program_d   = 1'b0;
`ifdef UART_RX_CHECKSUM_EN
        csum_d      = csum_q;
        csum_err_s  = 1'b0;
`endif
        case (pkt_state_q)
            P_HUNT: begin
                if (byte_valid_q && shift_q == 8'hA5) begin
                    pkt_state_d = P_PAYLOAD;
                    count_d     = 3'd0;
`ifdef UART_RX_CHECKSUM_EN
                    csum_d      = 8'd0;
`endif
                end else begin
                    pkt_state_d = P_HUNT;
                end
            end
            P_PAYLOAD: begin
                if (stop_err_q) begin
                    pkt_state_d = P_HUNT;
                end else if (byte_valid_q) begin
                    payload_d = {payload_q[PW-9:0], shift_q};
                    count_d   = count_q + 3'd1;
`ifdef UART_RX_CHECKSUM_EN
                    csum_d    = csum_step(csum_q, shift_q);
                    if (count_q == LAST_IDX) begin
                        pkt_state_d = P_HUNT;
                        if (shift_q == csum_q) begin
                            shape_d   = payload_q[39:28];
                            reg_d     = payload_q[27:16];
                            data_d    = payload_q[15:4];
                            program_d = 1'b1;
                        end else begin
                            csum_err_s = 1'b1;
                        end
                    end else begin
                        pkt_state_d = P_PAYLOAD;
                    end
`else
                    if (count_q == LAST_IDX) begin
                        pkt_state_d = P_HUNT;
                        shape_d     = payload_q[31:20];
                        reg_d       = payload_q[19:8];
                        data_d      = {payload_q[7:0], shift_q[7:4]};
                        program_d   = 1'b1;
                    end else begin
                        pkt_state_d = P_PAYLOAD;
                    end
`endif
                end else if (timeout_s) begin
                    pkt_state_d = P_HUNT;
                end else begin
                    pkt_state_d = P_PAYLOAD;
                end
            end
            default: begin
                pkt_state_d = P_HUNT;
            end
        endcase
    end

`ifdef UART_RX_CHECKSUM_EN
    assign frame_err_d = stop_err_s | csum_err_s;
`else
    assign frame_err_d = stop_err_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_state_q <= P_HUNT;
            count_q     <= 3'd0;
            payload_q   <= '0;
            to_cnt_q    <= '0;
            program_q   <= 1'b0;
            shape_q     <= 12'd0;
            reg_q       <= 12'd0;
            data_q      <= 12'd0;
            frame_err_q <= 1'b0;
        end else begin
            pkt_state_q <= pkt_state_d;
            count_q     <= count_d;
            payload_q   <= payload_d;
            to_cnt_q    <= to_cnt_d;
            program_q   <= program_d;
            shape_q     <= shape_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign program_out = program_q;
    assign shape_addr  = shape_q;
    assign reg_addr    = reg_q;
    assign data        = data_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_command_rx.sv
// Directed bench for uart_command_rx at 8 clocks per bit; also covers the checksum build when
// UART_RX_CHECKSUM_EN is defined.
module tb_uart_command_rx;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        serial_input = 1'b1;
    logic        program_out, frame_err;
    logic [11:0] shape_addr, reg_addr, data;

    int checks = 0;
    int failures = 0;
    int prog_pulses = 0;
    int prog_high = 0;
    int ferr_pulses = 0;
    int illegal_chg = 0;
    logic        prog_prev = 1'b0;
    logic        ferr_prev = 1'b0;
    logic [35:0] out_prev = 36'd0;
    int p0, f0;

    always #5 clk = ~clk;

    uart_command_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(16)) dut (
        .clk(clk), .rst(rst), .serial_input(serial_input),
        .program_out(program_out), .shape_addr(shape_addr), .reg_addr(reg_addr),
        .data(data), .frame_err(frame_err)
    );

    // Event monitor: strobe/error pulse counts and output stability between strobes.
    always @(negedge clk) begin
        if (rst) begin
            prog_prev = 1'b0;
            ferr_prev = 1'b0;
            out_prev  = {shape_addr, reg_addr, data};
        end else begin
            if (program_out) prog_high++;
            if (program_out && !prog_prev) prog_pulses++;
            if (frame_err && !ferr_prev) ferr_pulses++;
            if (!program_out && ({shape_addr, reg_addr, data} != out_prev)) illegal_chg++;
            prog_prev = program_out;
            ferr_prev = frame_err;
            out_prev  = {shape_addr, reg_addr, data};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_input = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        serial_input = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // A5 header, five payload bytes (optional idle gap after the second), checksum if enabled.
    task automatic send_packet(input logic [39:0] pl, input int gap_bits);
        logic [7:0] cs;
        cs = 8'd0;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_byte(pl[39 - 8*i -: 8], 1'b1);
            cs = cs ^ pl[39 - 8*i -: 8];
            if (i == 1 && gap_bits > 0) idle_bits(gap_bits);
        end
`ifdef UART_RX_CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
    endtask

    task automatic check_outs(input string tag, input logic [11:0] s, input logic [11:0] r, input logic [11:0] d);
        check({tag, ".shape"}, 64'(shape_addr), 64'(s));
        check({tag, ".reg"},   64'(reg_addr),   64'(r));
        check({tag, ".data"},  64'(data),       64'(d));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.program", 64'(program_out), 64'd0);
        check("rst.frame_err", 64'(frame_err), 64'd0);
        check_outs("rst", 12'h000, 12'h000, 12'h000);
        rst = 1'b0;
        idle_bits(2);

        // Timeout: 20-bit idle gap mid-packet aborts it; trailing bytes are junk in HUNT.
        p0 = prog_pulses; f0 = ferr_pulses;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle_bits(20);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h90, 1'b1);
        idle_bits(3);
        check("timeout.strobes", 64'(prog_pulses - p0), 64'd0);
        check("timeout.ferr", 64'(ferr_pulses - f0), 64'd0);
        check_outs("timeout", 12'h000, 12'h000, 12'h000);

        // Gap just below the timeout keeps the packet alive.
        p0 = prog_pulses;
        send_packet(40'h0FEDCBA987, 15);
        idle_bits(3);
        check("neartimeout.strobes", 64'(prog_pulses - p0), 64'd1);
        check_outs("neartimeout", 12'h0FE, 12'hDCB, 12'hA98);

        // Basic packet, then junk + packet back-to-back with no idle.
        p0 = prog_pulses; f0 = ferr_pulses;
        send_packet(40'h1234567890, 0);
        send_byte(8'h00, 1'b1);
        check("basic.strobes", 64'(prog_pulses - p0), 64'd1);
        check_outs("basic", 12'h123, 12'h456, 12'h789);
        send_byte(8'hFF, 1'b1);
        send_packet(40'hABCDEF0123, 0);
        idle_bits(3);
        check("junk.strobes", 64'(prog_pulses - p0), 64'd2);
        check("junk.ferr", 64'(ferr_pulses - f0), 64'd0);
        check_outs("junk", 12'hABC, 12'hDEF, 12'h012);

        // Stop bit forced low inside a packet.
        p0 = prog_pulses; f0 = ferr_pulses;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        idle_bits(2);
        check("ferr.pulse", 64'(ferr_pulses - f0), 64'd1);
        check("ferr.strobes", 64'(prog_pulses - p0), 64'd0);
        check_outs("ferr.hold", 12'hABC, 12'hDEF, 12'h012);
        send_packet(40'h1111111110, 0);
        idle_bits(3);
        check("ferr.next_strobes", 64'(prog_pulses - p0), 64'd1);
        check("ferr.total", 64'(ferr_pulses - f0), 64'd1);
        check_outs("ferr.next", 12'h111, 12'h111, 12'h111);

        // Reset in the middle of the third payload byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        #1;
        check("midrst.program", 64'(program_out), 64'd0);
        check("midrst.frame_err", 64'(frame_err), 64'd0);
        check_outs("midrst", 12'h000, 12'h000, 12'h000);
        serial_input = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        p0 = prog_pulses;
        send_packet(40'h1234567890, 0);
        idle_bits(3);
        check("postrst.strobes", 64'(prog_pulses - p0), 64'd1);
        check_outs("postrst", 12'h123, 12'h456, 12'h789);

`ifdef UART_RX_CHECKSUM_EN
        p0 = prog_pulses; f0 = ferr_pulses;
        send_byte(8'hA5, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(8'h89, 1'b1);
        idle_bits(3);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h90, 1'b1);
        send_byte(8'h99, 1'b1);
        idle_bits(3);
        check("csum.bad_strobes", 64'(prog_pulses - p0), 64'd0);
        check("csum.bad_ferr", 64'(ferr_pulses - f0), 64'd2);
        check_outs("csum.hold", 12'h123, 12'h456, 12'h789);
`endif

        check("strobe_width", 64'(prog_high), 64'(prog_pulses));
        check("outputs_stable", 64'(illegal_chg), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
